// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one M-stage access becomes one word-aligned
// req/ack bus transaction, with byte lanes, load extension, stall and fault flags.
module load_store_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MemWrite_M,
  input  logic              MemRead_M,
  input  logic [2:0]        Funct3_M,
  input  logic [ADDR_W-1:0] Addr_M,
  input  logic [31:0]       WriteData_M,
  output logic              Stall_M,
  output logic [31:0]       ReadData_W,
  output logic              Misalign_M,
  output logic              Fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_err,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;

  logic        is_ld, is_st, ld_ok, st_ok, mis, bad, start, hit;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, sh, ext;
  logic [7:0]  bt;
  logic [15:0] hf;

  always_comb begin
    is_ld = MemRead_M & ~MemWrite_M;
    is_st = MemWrite_M & ~MemRead_M;
    ld_ok = Funct3_M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_ok = Funct3_M inside {3'b000, 3'b001, 3'b010};
    case (Funct3_M[1:0])
      2'b01:   mis = Addr_M[0];
      2'b10:   mis = Addr_M[1:0] != 2'b00;
      default: mis = 1'b0;
    endcase
    bad   = (is_ld & (~ld_ok | mis)) | (is_st & (~st_ok | mis));
    start = (state == IDLE) & (is_ld | is_st) & ~bad;
    hit   = cnt == 8'(TIMEOUT - 1);
  end

  // Reads always fetch the full word; lane selection happens on the way back.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = WriteData_M;
    if (is_st) begin
      case (Funct3_M[1:0])
        2'b00: begin
          be_d    = 4'b0001 << Addr_M[1:0];
          wdata_d = {4{WriteData_M[7:0]}};
        end
        2'b01: begin
          be_d    = 4'b0011 << {Addr_M[1], 1'b0};
          wdata_d = {2{WriteData_M[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sh  = mem_rdata >> {lane_q, 3'b000};
    bt  = sh[7:0];
    hf  = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ext = {{24{bt[7]}}, bt};
      3'b001:  ext = {{16{hf[15]}}, hf};
      3'b100:  ext = {24'h0, bt};
      3'b101:  ext = {16'h0, hf};
      default: ext = mem_rdata;
    endcase
  end

  // Flag outputs are gated by reset so an abandoned access never leaks a stall.
  assign Stall_M    = Reset & (start | (state == REQ));
  assign Misalign_M = Reset & (state == IDLE) & bad;
  assign Fault      = Reset & (((state == IDLE) & MemRead_M & MemWrite_M) |
                               ((state == REQ) & ((mem_ack & mem_err) | (~mem_ack & hit))));
  assign mem_req    = state == REQ;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      f3_q       <= 3'd0;
      lane_q     <= 2'd0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'd0;
      mem_wdata  <= 32'd0;
      ReadData_W <= 32'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state     <= REQ;
          cnt       <= 8'd0;
          f3_q      <= Funct3_M;
          lane_q    <= Addr_M[1:0];
          mem_we    <= is_st;
          mem_addr  <= {Addr_M[ADDR_W-1:2], 2'b00};
          mem_be    <= be_d;
          mem_wdata <= wdata_d;
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          if (mem_ack & ~mem_err) begin
            if (!mem_we) ReadData_W <= ext;
            state <= DONE;
          end else if ((mem_ack & mem_err) | hit) begin
            if (!mem_we) ReadData_W <= 32'd0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit: per-access table plus hand-written
// timeout and mid-transaction reset sequences.
module tb_load_store_unit;

  logic        Clk = 1'b0, Reset = 1'b0;
  logic        MemWrite_M = 1'b0, MemRead_M = 1'b0;
  logic [2:0]  Funct3_M = 3'd0;
  logic [31:0] Addr_M = 32'd0, WriteData_M = 32'd0;
  logic        Stall_M, Misalign_M, Fault, mem_req, mem_we;
  logic [31:0] ReadData_W, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0, mem_err = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  logic        to_rd = 1'b0, to_wr = 1'b0;
  logic        t_stall, t_mis, t_fault, t_req, t_we;
  logic [31:0] t_rdw, t_addr, t_wdata;
  logic [3:0]  t_be;

  always #5 Clk = ~Clk;

  load_store_unit dut (
    .Clk(Clk), .Reset(Reset), .MemWrite_M(MemWrite_M), .MemRead_M(MemRead_M),
    .Funct3_M(Funct3_M), .Addr_M(Addr_M), .WriteData_M(WriteData_M),
    .Stall_M(Stall_M), .ReadData_W(ReadData_W), .Misalign_M(Misalign_M), .Fault(Fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.TIMEOUT(4)) u_to (
    .Clk(Clk), .Reset(Reset), .MemWrite_M(to_wr), .MemRead_M(to_rd),
    .Funct3_M(Funct3_M), .Addr_M(Addr_M), .WriteData_M(WriteData_M),
    .Stall_M(t_stall), .ReadData_W(t_rdw), .Misalign_M(t_mis), .Fault(t_fault),
    .mem_req(t_req), .mem_we(t_we), .mem_addr(t_addr), .mem_be(t_be),
    .mem_wdata(t_wdata), .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rdata;
    int          ack_at;
    logic        err;
    int          e_stall, e_req;
    logic        e_mis, e_fault;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_rdw;
  } vec_t;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    int stall_n = 0, req_n = 0, mis_n = 0, flt_n = 0;
    logic [3:0]  be0 = 4'd0;
    logic [31:0] a0 = 32'd0, w0 = 32'd0;
    logic        we0 = 1'b0, unstable = 1'b0;
    bit done = 0;
    @(negedge Clk);
    MemRead_M = v.rd; MemWrite_M = v.wr; Funct3_M = v.f3;
    Addr_M = v.addr; WriteData_M = v.wd; mem_rdata = v.rdata;
    for (int c = 0; c < 300 && !done; c++) begin
      if (mem_req) req_n++;
      mem_ack = mem_req && (req_n == v.ack_at);
      mem_err = mem_ack & v.err;
      #1;
      stall_n += int'(Stall_M); mis_n += int'(Misalign_M); flt_n += int'(Fault);
      if (mem_req) begin
        if (req_n == 1) begin
          be0 = mem_be; a0 = mem_addr; w0 = mem_wdata; we0 = mem_we;
        end else if (mem_be !== be0 || mem_addr !== a0 || mem_wdata !== w0 || mem_we !== we0)
          unstable = 1'b1;
      end
      if (!Stall_M) done = 1;
      @(posedge Clk); #1;
      mem_ack = 1'b0; mem_err = 1'b0;
      if (!done) @(negedge Clk);
    end
    MemRead_M = 1'b0; MemWrite_M = 1'b0;
    chk($sformatf("v%0d bounded", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d stall_cycles", idx), 32'(stall_n), 32'(v.e_stall));
    chk($sformatf("v%0d req_cycles", idx), 32'(req_n), 32'(v.e_req));
    chk($sformatf("v%0d misalign", idx), 32'(mis_n), 32'(v.e_mis));
    chk($sformatf("v%0d fault", idx), 32'(flt_n), 32'(v.e_fault));
    if (v.e_req > 0) begin
      chk($sformatf("v%0d mem_addr", idx), a0, v.e_addr);
      chk($sformatf("v%0d mem_be", idx), 32'(be0), 32'(v.e_be));
      chk($sformatf("v%0d mem_we", idx), 32'(we0), 32'(v.wr));
      chk($sformatf("v%0d stable", idx), 32'(unstable), 32'd0);
      if (v.wr) chk($sformatf("v%0d mem_wdata", idx), w0, v.e_wdata);
    end
    chk($sformatf("v%0d ReadData_W", idx), ReadData_W, v.e_rdw);
  endtask

  vec_t vt[14];

  initial begin
    //        rd wr  f3     addr          wd            rdata         ack err stl req mis flt be       addr          wdata         rdw
    vt[0]  = '{0, 1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0,        1, 0, 2, 1, 0, 0, 4'b1000, 32'h0000_1000, 32'hA5A5_A5A5, 32'h0};
    vt[1]  = '{1, 0, 3'b000, 32'h0000_2002, 32'h0,         32'h00F0_0000, 1, 0, 2, 1, 0, 0, 4'b1111, 32'h0000_2000, 32'h0,        32'hFFFF_FFF0};
    vt[2]  = '{1, 0, 3'b100, 32'h0000_2002, 32'h0,         32'h00F0_0000, 1, 0, 2, 1, 0, 0, 4'b1111, 32'h0000_2000, 32'h0,        32'h0000_00F0};
    vt[3]  = '{1, 0, 3'b101, 32'h0000_2002, 32'h0,         32'h8001_0000, 1, 0, 2, 1, 0, 0, 4'b1111, 32'h0000_2000, 32'h0,        32'h0000_8001};
    vt[4]  = '{0, 1, 3'b010, 32'h0000_1002, 32'h1234_5678, 32'h0,        1, 0, 0, 0, 1, 0, 4'b0000, 32'h0,          32'h0,        32'h0000_8001};
    vt[5]  = '{1, 0, 3'b001, 32'h0000_1001, 32'h0,         32'h0,        1, 0, 0, 0, 1, 0, 4'b0000, 32'h0,          32'h0,        32'h0000_8001};
    vt[6]  = '{1, 0, 3'b011, 32'h0000_1000, 32'h0,         32'h0,        1, 0, 0, 0, 1, 0, 4'b0000, 32'h0,          32'h0,        32'h0000_8001};
    vt[7]  = '{1, 0, 3'b010, 32'h0000_3000, 32'h0,         32'h1234_5678, 5, 0, 6, 5, 0, 0, 4'b1111, 32'h0000_3000, 32'h0,        32'h1234_5678};
    vt[8]  = '{1, 0, 3'b010, 32'h0000_3004, 32'h0,         32'hDEAD_BEEF, 1, 1, 2, 1, 0, 1, 4'b1111, 32'h0000_3004, 32'h0,        32'h0};
    vt[9]  = '{0, 1, 3'b001, 32'h0000_1006, 32'h0000_BEEF, 32'h0,        2, 0, 3, 2, 0, 0, 4'b1100, 32'h0000_1004, 32'hBEEF_BEEF, 32'h0};
    vt[10] = '{1, 0, 3'b001, 32'h0000_4002, 32'h0,         32'h8001_0000, 1, 0, 2, 1, 0, 0, 4'b1111, 32'h0000_4000, 32'h0,        32'hFFFF_8001};
    vt[11] = '{1, 0, 3'b000, 32'h0000_4000, 32'h0,         32'hAAAA_AA7F, 1, 0, 2, 1, 0, 0, 4'b1111, 32'h0000_4000, 32'h0,        32'h0000_007F};
    vt[12] = '{1, 1, 3'b010, 32'h0000_5000, 32'h0,         32'h0,        1, 0, 0, 0, 0, 1, 4'b0000, 32'h0,          32'h0,        32'h0000_007F};
    vt[13] = '{0, 1, 3'b100, 32'h0000_5000, 32'h0,         32'h0,        1, 0, 0, 0, 1, 0, 4'b0000, 32'h0,          32'h0,        32'h0000_007F};

    #1;
    chk("reset Stall_M", 32'(Stall_M), 32'd0);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset ReadData_W", ReadData_W, 32'd0);
    chk("reset mem_be", 32'(mem_be), 32'd0);
    chk("reset Fault", 32'(Fault), 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;

    for (int i = 0; i < 14; i++) run(vt[i], i);

    // Timeout instance: a load that never gets an ack.
    begin
      int req_n = 0, stall_n = 0, flt_n = 0, flt_at = 0;
      bit done = 0;
      @(negedge Clk);
      to_rd = 1'b1; Funct3_M = 3'b010; Addr_M = 32'h0000_0040;
      for (int c = 0; c < 50 && !done; c++) begin
        if (t_req) req_n++;
        #1;
        stall_n += int'(t_stall);
        if (t_fault) begin flt_n++; flt_at = req_n; end
        if (!t_stall) done = 1;
        @(posedge Clk); #1;
        if (!done) @(negedge Clk);
      end
      to_rd = 1'b0;
      chk("timeout bounded", 32'(done), 32'd1);
      chk("timeout req_cycles", 32'(req_n), 32'd4);
      chk("timeout fault_count", 32'(flt_n), 32'd1);
      chk("timeout fault_cycle", 32'(flt_at), 32'd4);
      chk("timeout stall_cycles", 32'(stall_n), 32'd5);
      chk("timeout ReadData_W", t_rdw, 32'd0);
      @(negedge Clk);
      chk("timeout idle req", 32'(t_req), 32'd0);
      chk("timeout idle stall", 32'(t_stall), 32'd0);
    end

    // Reset pulled low while a load is waiting in REQ.
    @(negedge Clk);
    MemRead_M = 1'b1; Funct3_M = 3'b010; Addr_M = 32'h0000_6000;
    @(negedge Clk);
    chk("rst in REQ", 32'(mem_req), 32'd1);
    Reset = 1'b0;
    #1;
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst Stall_M", 32'(Stall_M), 32'd0);
    chk("rst Fault", 32'(Fault), 32'd0);
    chk("rst ReadData_W", ReadData_W, 32'd0);
    MemRead_M = 1'b0;
    @(negedge Clk);
    #2 Reset = 1'b1;
    run('{1, 0, 3'b010, 32'h0000_6000, 32'h0, 32'hCAFE_F00D, 1, 0, 2, 1, 0, 0,
          4'b1111, 32'h0000_6000, 32'h0, 32'hCAFE_F00D}, 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
